sp_if_order_seq: RTL and testbench

SP_IF_ORDER_SEQ -- requirements
Module: sp_if_order_seq

---
 rtl/sp_if_order_seq.sv | 184 ++++++++++++++++++
 tb/tb_sp_if_order_seq.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_if_order_seq.sv
// Order-table sequencer: streams a ROM address range (optionally looping)
// through a credit-limited output FIFO to a ready/valid consumer.
module sp_if_order_seq #(
    parameter int DW      = 32,
    parameter int AW      = 10,
    parameter int NBANK   = 2,
    parameter int ROM_LAT = 2
) (
    input  logic                     i_clk156m,
    input  logic                     i_arst,
    input  logic                     i_start,
    input  logic                     i_stop,
    input  logic                     i_mode_loop,
    input  logic [$clog2(NBANK)-1:0] i_bank_sel,
    input  logic [AW-1:0]            i_start_adr,
    input  logic [AW-1:0]            i_end_adr,
    output logic [AW-1:0]            o_rom_rd_adr,
    output logic [$clog2(NBANK)-1:0] o_rom_bank,
    output logic                     o_rom_rden,
    input  logic [DW-1:0]            i_rom_rd_data,
    output logic [DW-1:0]            o_order_data,
    output logic                     o_order_valid,
    input  logic                     i_order_ready,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err
);

    localparam int DEPTH = ROM_LAT + 2;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int BW    = $clog2(NBANK);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        start_q, start_d;
    logic [AW-1:0]        end_q, end_d;
    logic [AW-1:0]        nxt_q, nxt_d;
    logic [AW-1:0]        adr_q, adr_d;
    logic [BW-1:0]        bank_q, bank_d;
    logic                 loop_q, loop_d;
    logic                 rden_q, rden_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;
    logic [ROM_LAT-1:0]   pipe_q, pipe_d;
    logic [DW-1:0]        mem_q [DEPTH];
    logic [DW-1:0]        mem_d [DEPTH];
    logic [PW-1:0]        wr_q, wr_d;
    logic [PW-1:0]        rd_q, rd_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        tot_q, tot_d;

    logic issue;
    logic pop;
    logic wr;
    logic room;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop  = (cnt_q != '0) && i_order_ready;
    assign wr   = pipe_q[ROM_LAT-1];
    // tot counts FIFO words plus reads issued but not yet written back
    assign room = (tot_q - CW'(pop)) < CW'(DEPTH);

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        end_d   = end_q;
        nxt_d   = nxt_q;
        adr_d   = adr_q;
        bank_d  = bank_q;
        loop_d  = loop_q;
        err_d   = 1'b0;
        done_d  = 1'b0;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (i_start_adr <= i_end_adr) begin
                        start_d = i_start_adr;
                        end_d   = i_end_adr;
                        bank_d  = i_bank_sel;
                        loop_d  = i_mode_loop;
                        adr_d   = i_start_adr;
                        issue   = 1'b1;
                        if (i_start_adr == i_end_adr) begin
                            nxt_d   = i_start_adr;
                            state_d = i_mode_loop ? RUN : DRAIN;
                        end else begin
                            nxt_d   = i_start_adr + 1'b1;
                            state_d = RUN;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (i_stop) begin
                    state_d = DRAIN;
                end else if (room) begin
                    issue = 1'b1;
                    adr_d = nxt_q;
                    if (nxt_q == end_q) begin
                        if (loop_q) nxt_d = start_q;
                        else        state_d = DRAIN;
                    end else begin
                        nxt_d = nxt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (tot_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rden_d = issue;
        pipe_d = (pipe_q << 1) | ROM_LAT'(rden_q);
        tot_d  = tot_q + CW'(issue) - CW'(pop);
        mem_d  = mem_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        if (wr) begin
            mem_d[wr_q] = i_rom_rd_data;
            wr_d        = ptr_inc(wr_q);
        end
        if (pop) rd_d = ptr_inc(rd_q);
        cnt_d = cnt_q + CW'(wr) - CW'(pop);
    end

    always_ff @(posedge i_clk156m or posedge i_arst) begin
        if (i_arst) begin
            state_q <= IDLE;
            start_q <= '0;
            end_q   <= '0;
            nxt_q   <= '0;
            adr_q   <= '0;
            bank_q  <= '0;
            loop_q  <= 1'b0;
            rden_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            pipe_q  <= '0;
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            tot_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            end_q   <= end_d;
            nxt_q   <= nxt_d;
            adr_q   <= adr_d;
            bank_q  <= bank_d;
            loop_q  <= loop_d;
            rden_q  <= rden_d;
            err_q   <= err_d;
            done_q  <= done_d;
            pipe_q  <= pipe_d;
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            tot_q   <= tot_d;
        end
    end

    assign o_rom_rd_adr  = adr_q;
    assign o_rom_bank    = bank_q;
    assign o_rom_rden    = rden_q;
    assign o_order_data  = mem_q[rd_q];
    assign o_order_valid = (cnt_q != '0);
    assign o_busy        = (state_q != IDLE);
    assign o_done        = done_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_sp_if_order_seq.sv
// Directed bench for sp_if_order_seq with a fixed-latency ROM model.
module tb_sp_if_order_seq;

    localparam int DW      = 32;
    localparam int AW      = 10;
    localparam int NBANK   = 2;
    localparam int ROM_LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start, i_stop, i_mode_loop, i_order_ready;
    logic [0:0]    i_bank_sel;
    logic [AW-1:0] i_start_adr, i_end_adr;
    logic [AW-1:0] o_rom_rd_adr;
    logic [0:0]    o_rom_bank;
    logic          o_rom_rden;
    logic [DW-1:0] i_rom_rd_data;
    logic [DW-1:0] o_order_data;
    logic          o_order_valid, o_busy, o_done, o_err;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] got[$];
    int issued, acc, outst_max;
    logic [DW-1:0] rom_pipe [ROM_LAT];

    always #5 clk = ~clk;

    sp_if_order_seq #(
        .DW(DW), .AW(AW), .NBANK(NBANK), .ROM_LAT(ROM_LAT)
    ) dut (
        .i_clk156m    (clk),
        .i_arst       (rst),
        .i_start      (i_start),
        .i_stop       (i_stop),
        .i_mode_loop  (i_mode_loop),
        .i_bank_sel   (i_bank_sel),
        .i_start_adr  (i_start_adr),
        .i_end_adr    (i_end_adr),
        .o_rom_rd_adr (o_rom_rd_adr),
        .o_rom_bank   (o_rom_bank),
        .o_rom_rden   (o_rom_rden),
        .i_rom_rd_data(i_rom_rd_data),
        .o_order_data (o_order_data),
        .o_order_valid(o_order_valid),
        .i_order_ready(i_order_ready),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    function automatic logic [DW-1:0] rom_word(input logic b, input logic [AW-1:0] a);
        return 32'hA500_0000 | (32'(b) << 16) | 32'(a);
    endfunction

    // ROM: data for the address on the bus appears ROM_LAT cycles later
    always @(posedge clk) begin
        rom_pipe[0] <= rom_word(o_rom_bank, o_rom_rd_adr);
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign i_rom_rd_data = rom_pipe[ROM_LAT-1];

    always @(posedge clk) begin
        if (!rst) begin
            if (o_order_valid && i_order_ready) begin
                got.push_back(o_order_data);
                acc++;
            end
            if (o_rom_rden) issued++;
            if (issued - acc > outst_max) outst_max = issued - acc;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon;
        got.delete();
        issued    = 0;
        acc       = 0;
        outst_max = 0;
    endtask

    task automatic pulse_start(input logic b, input logic [AW-1:0] s,
                               input logic [AW-1:0] e, input logic lp);
        i_bank_sel  = b;
        i_start_adr = s;
        i_end_adr   = e;
        i_mode_loop = lp;
        i_start     = 1'b1;
        tick;
        i_start     = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        total++;
        if ({o_rom_rden, o_order_valid, o_busy, o_done, o_err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {o_rom_rden, o_order_valid, o_busy, o_done, o_err});
        end
        total++;
        if (o_rom_rd_adr !== '0 || o_rom_bank !== '0) begin
            bad++;
            $display("FAIL reset_adr: got %h/%h want 0/0", o_rom_rd_adr, o_rom_bank);
        end
        total++;
        if (o_order_data !== '0) begin
            bad++;
            $display("FAIL reset_data: got %h want 0", o_order_data);
        end
        tick;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_single;
        int first_v, done_at, ndone;
        logic ok;
        clear_mon;
        i_order_ready = 1'b1;
        pulse_start(1'b0, 10'h010, 10'h013, 1'b0);
        total++;
        if (o_rom_rden !== 1'b1 || o_rom_rd_adr !== 10'h010 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL single_first_rd: got rden=%b adr=%h busy=%b want 1 010 1",
                     o_rom_rden, o_rom_rd_adr, o_busy);
        end
        first_v = -1;
        done_at = -1;
        ndone   = 0;
        for (int k = 1; k <= 30; k++) begin
            tick;
            if (o_order_valid && first_v < 0) first_v = k;
            if (o_done) begin
                ndone++;
                if (done_at < 0) done_at = k;
            end
        end
        total++;
        if (first_v != 3) begin
            bad++;
            $display("FAIL single_latency: got %0d want 3", first_v);
        end
        total++;
        if (done_at != 8 || ndone != 1) begin
            bad++;
            $display("FAIL single_done: got at=%0d n=%0d want at=8 n=1", done_at, ndone);
        end
        ok = (got.size() == 4);
        for (int i = 0; i < got.size() && ok; i++)
            if (got[i] !== rom_word(1'b0, 10'(10'h010 + i))) ok = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL single_seq: got n=%0d want 4 words 010..013", got.size());
        end
        total++;
        if (o_busy !== 1'b0) begin
            bad++;
            $display("FAIL single_busy: got %b want 0", o_busy);
        end
    endtask

    task automatic test_backpressure;
        int ndone;
        logic pv, pr, ok;
        logic [DW-1:0] pd;
        clear_mon;
        ndone = 0;
        i_order_ready = 1'b0;
        pulse_start(1'b0, 10'h000, 10'h007, 1'b0);
        for (int k = 0; k < 120; k++) begin
            i_order_ready = (k % 3 == 0);
            pv = o_order_valid;
            pd = o_order_data;
            pr = i_order_ready;
            tick;
            if (o_done) ndone++;
            if (pv && !pr) begin
                total++;
                if (o_order_valid !== 1'b1 || o_order_data !== pd) begin
                    bad++;
                    $display("FAIL bp_stable: got v=%b d=%h want v=1 d=%h",
                             o_order_valid, o_order_data, pd);
                end
            end
        end
        i_order_ready = 1'b1;
        ok = (got.size() == 8);
        for (int i = 0; i < got.size() && ok; i++)
            if (got[i] !== rom_word(1'b0, 10'(i))) ok = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL bp_seq: got n=%0d want 8 words 000..007", got.size());
        end
        total++;
        if (outst_max > 4) begin
            bad++;
            $display("FAIL bp_occupancy: got %0d want <=4", outst_max);
        end
        total++;
        if (ndone != 1) begin
            bad++;
            $display("FAIL bp_done: got %0d want 1", ndone);
        end
    endtask

    task automatic test_loop;
        int ndone, rd_after;
        logic ok;
        clear_mon;
        ndone    = 0;
        rd_after = 0;
        i_order_ready = 1'b1;
        pulse_start(1'b0, 10'h3FE, 10'h3FF, 1'b1);
        for (int k = 0; k < 50 && got.size() < 5; k++) tick;
        total++;
        if (got.size() < 5) begin
            bad++;
            $display("FAIL loop_timeout: got %0d words want >=5", got.size());
        end
        i_stop = 1'b1;
        tick;
        i_stop = 1'b0;
        total++;
        if (o_rom_rden !== 1'b0) begin
            bad++;
            $display("FAIL loop_stop_rd: got %b want 0", o_rom_rden);
        end
        for (int k = 0; k < 30; k++) begin
            tick;
            if (o_rom_rden) rd_after++;
            if (o_done) ndone++;
        end
        ok = (got.size() >= 5) && (got.size() == issued);
        for (int i = 0; i < got.size() && ok; i++)
            if (got[i] !== rom_word(1'b0, (i % 2) ? 10'h3FF : 10'h3FE)) ok = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL loop_seq: got n=%0d issued=%0d want equal alternating 3FE/3FF",
                     got.size(), issued);
        end
        total++;
        if (ndone != 1 || rd_after != 0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL loop_drain: got done=%0d rd=%0d busy=%b want 1 0 0",
                     ndone, rd_after, o_busy);
        end
    endtask

    task automatic test_error;
        clear_mon;
        pulse_start(1'b0, 10'h020, 10'h01F, 1'b0);
        total++;
        if (o_err !== 1'b1 || o_busy !== 1'b0 || o_rom_rden !== 1'b0) begin
            bad++;
            $display("FAIL err_pulse: got err=%b busy=%b rden=%b want 1 0 0",
                     o_err, o_busy, o_rom_rden);
        end
        tick;
        total++;
        if (o_err !== 1'b0) begin
            bad++;
            $display("FAIL err_width: got %b want 0", o_err);
        end
        i_stop = 1'b1;
        tick;
        i_stop = 1'b0;
        repeat (4) tick;
        total++;
        if (issued != 0 || o_busy !== 1'b0 || o_err !== 1'b0) begin
            bad++;
            $display("FAIL err_idle: got rd=%0d busy=%b err=%b want 0 0 0",
                     issued, o_busy, o_err);
        end
    endtask

    task automatic test_bank_busy;
        int ndone;
        logic ok;
        clear_mon;
        ndone = 0;
        i_order_ready = 1'b1;
        pulse_start(1'b1, 10'h040, 10'h047, 1'b0);
        i_bank_sel = 1'b0;
        tick;
        pulse_start(1'b0, 10'h100, 10'h101, 1'b1);
        for (int k = 0; k < 40; k++) begin
            if (o_busy) begin
                total++;
                if (o_rom_bank !== 1'b1) begin
                    bad++;
                    $display("FAIL bank_hold: got %b want 1", o_rom_bank);
                end
            end
            tick;
            if (o_done) ndone++;
        end
        ok = (got.size() == 8);
        for (int i = 0; i < got.size() && ok; i++)
            if (got[i] !== rom_word(1'b1, 10'(10'h040 + i))) ok = 1'b0;
        total++;
        if (!ok || ndone != 1) begin
            bad++;
            $display("FAIL busy_start: got n=%0d done=%0d want 8 words bank1 040..047 done=1",
                     got.size(), ndone);
        end
    endtask

    task automatic test_reset_mid;
        int ndone;
        logic ok;
        clear_mon;
        ndone = 0;
        i_order_ready = 1'b0;
        pulse_start(1'b0, 10'h080, 10'h08F, 1'b0);
        repeat (5) tick;
        total++;
        if (o_order_valid !== 1'b1 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_pre: got v=%b busy=%b want 1 1", o_order_valid, o_busy);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({o_rom_rden, o_order_valid, o_busy, o_done, o_err} !== 5'b0 ||
            o_rom_rd_adr !== '0 || o_rom_bank !== '0 || o_order_data !== '0) begin
            bad++;
            $display("FAIL rstmid_outs: got ctl=%b adr=%h data=%h want 0",
                     {o_rom_rden, o_order_valid, o_busy, o_done, o_err},
                     o_rom_rd_adr, o_order_data);
        end
        tick;
        rst = 1'b0;
        clear_mon;
        i_order_ready = 1'b1;
        pulse_start(1'b0, 10'h0A0, 10'h0A2, 1'b0);
        total++;
        if (o_rom_rden !== 1'b1 || o_rom_rd_adr !== 10'h0A0) begin
            bad++;
            $display("FAIL rstmid_restart: got rden=%b adr=%h want 1 0A0",
                     o_rom_rden, o_rom_rd_adr);
        end
        for (int k = 0; k < 20; k++) begin
            tick;
            if (o_done) ndone++;
        end
        ok = (got.size() == 3);
        for (int i = 0; i < got.size() && ok; i++)
            if (got[i] !== rom_word(1'b0, 10'(10'h0A0 + i))) ok = 1'b0;
        total++;
        if (!ok || ndone != 1) begin
            bad++;
            $display("FAIL rstmid_seq: got n=%0d done=%0d want 3 words 0A0..0A2 done=1",
                     got.size(), ndone);
        end
    endtask

    initial begin
        rst           = 1'b0;
        i_start       = 1'b0;
        i_stop        = 1'b0;
        i_mode_loop   = 1'b0;
        i_order_ready = 1'b1;
        i_bank_sel    = 1'b0;
        i_start_adr   = '0;
        i_end_adr     = '0;
        clear_mon;
        #2;
        test_reset;
        test_single;
        test_backpressure;
        test_loop;
        test_error;
        test_bank_busy;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
